// File: rtl/anton_neopixel_apb_multi.sv
// APB slave with an on-chip pixel buffer that drives CHANNELS WS2812 strings in lock-step.
// Control/status registers, channel mask, continuous refresh and a sticky frame-done flag.
module anton_neopixel_apb_multi #(
  parameter int unsigned CHANNELS          = 2,
  parameter int unsigned BYTES_PER_CHANNEL = 48,
  parameter int unsigned CLK_DIV           = 8,
  parameter int unsigned RESET_DELAY       = 520
) (
  input  logic                apbPclk,
  input  logic                apbPresern,
  input  logic                syncStart,
  input  logic                apbPselx,
  input  logic                apbPenable,
  input  logic                apbPwrite,
  input  logic [19:0]         apbPaddr,
  input  logic [7:0]          apbPwData,
  output logic [7:0]          apbPrData,
  output logic                apbPready,
  output logic                apbPslverr,
  output logic [CHANNELS-1:0] neoData,
  output logic [1:0]          neoState
);

  localparam int unsigned Depth    = CHANNELS * BYTES_PER_CHANNEL;
  localparam int unsigned MemAw    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned ByteBits = $clog2(BYTES_PER_CHANNEL);
  localparam int unsigned ChBits   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ByteW    = (BYTES_PER_CHANNEL > 1) ? ByteBits : 1;
  localparam int unsigned PsW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RstW     = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2,
    StRst  = 2'd3
  } neoStateT;

  logic [7:0]          pixelMem [Depth];
  neoStateT            stateQ;
  logic                cont, syncEn, done, syncPrev, pslverr;
  logic [CHANNELS-1:0] chMask, maskQ, neoDataQ;
  logic [PsW-1:0]      prescale;
  logic [2:0]          slot, bitIdx;
  logic [ByteW-1:0]    byteIdx;
  logic [RstW-1:0]     rstCnt;
  logic [7:0]          dataQ [CHANNELS];
  logic [7:0]          prData, rdData;

  logic                isBuf, addrErr, apbSetup, wrEn, regWr, startReq, tick, busy;
  logic [31:0]         wordLow, byteField, chField, upperField;
  logic [MemAw-1:0]    memAddr;
  logic                unusedAddrBits;

  assign unusedAddrBits = ^apbPaddr[1:0];

  // Word index split: W[17] selects the buffer, the rest is byte/channel/must-be-zero fields.
  assign isBuf      = apbPaddr[19];
  assign wordLow    = {15'b0, apbPaddr[18:2]};
  assign byteField  = wordLow & ((32'd1 << ByteBits) - 32'd1);
  assign chField    = (wordLow >> ByteBits) & ((32'd1 << ChBits) - 32'd1);
  assign upperField = wordLow >> (ByteBits + ChBits);
  assign memAddr    = MemAw'(chField * BYTES_PER_CHANNEL + byteField);
  assign addrErr    = isBuf ? ((byteField >= BYTES_PER_CHANNEL) || (chField >= CHANNELS) ||
                               (upperField != 32'd0))
                            : (wordLow > 32'd2);

  assign apbSetup = apbPselx & ~apbPenable;
  assign wrEn     = apbPselx & apbPenable & apbPwrite & ~addrErr;
  assign regWr    = wrEn & ~isBuf;
  assign busy     = (stateQ != StIdle);
  assign tick     = (prescale == PsW'(CLK_DIV - 1));
  assign startReq = (regWr && wordLow == 32'd0 && apbPwData[1]) ||
                    (syncEn && syncStart && !syncPrev);

  always_comb begin
    rdData = 8'h00;
    if (isBuf)                  rdData = pixelMem[memAddr];
    else if (wordLow == 32'd0)  rdData = {5'b0, syncEn, 1'b0, cont};
    else if (wordLow == 32'd1)  rdData = {4'b0, done, stateQ, busy};
    else if (wordLow == 32'd2)  rdData = 8'(chMask);
  end

  always_ff @(posedge apbPclk) begin
    if (wrEn && isBuf) pixelMem[memAddr] <= apbPwData;
  end

  always_ff @(posedge apbPclk or negedge apbPresern) begin
    if (!apbPresern) begin
      stateQ   <= StIdle;
      cont     <= 1'b0;
      syncEn   <= 1'b0;
      done     <= 1'b0;
      syncPrev <= 1'b0;
      pslverr  <= 1'b0;
      prData   <= 8'h00;
      chMask   <= '1;
      maskQ    <= '0;
      neoDataQ <= '0;
      prescale <= '0;
      slot     <= 3'd0;
      bitIdx   <= 3'd7;
      byteIdx  <= '0;
      rstCnt   <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) dataQ[c] <= 8'h00;
    end else begin
      syncPrev <= syncStart;
      pslverr  <= apbSetup & addrErr;
      if (apbSetup && !apbPwrite) prData <= addrErr ? 8'h00 : rdData;

      if (regWr && wordLow == 32'd0) begin
        cont   <= apbPwData[0];
        syncEn <= apbPwData[2];
      end
      if (regWr && wordLow == 32'd2) chMask <= apbPwData[CHANNELS-1:0];
      if (regWr && wordLow == 32'd1 && apbPwData[3]) done <= 1'b0;

      // Held at 0 through LOAD so the first bit slot gets a full tick period.
      if (stateQ == StSend || stateQ == StRst) prescale <= tick ? '0 : prescale + PsW'(1);
      else                                     prescale <= '0;

      case (stateQ)
        StIdle: begin
          neoDataQ <= '0;
          if (startReq) stateQ <= StLoad;
        end
        StLoad: begin
          maskQ    <= chMask;
          neoDataQ <= chMask;
          slot     <= 3'd0;
          bitIdx   <= 3'd7;
          byteIdx  <= '0;
          for (int unsigned c = 0; c < CHANNELS; c++)
            dataQ[c] <= pixelMem[MemAw'(c * BYTES_PER_CHANNEL)];
          stateQ   <= StSend;
        end
        StSend: begin
          if (tick) begin
            if (slot == 3'd7) begin
              slot <= 3'd0;
              if (bitIdx == 3'd0) begin
                if (byteIdx == ByteW'(BYTES_PER_CHANNEL - 1)) begin
                  neoDataQ <= '0;
                  rstCnt   <= '0;
                  stateQ   <= StRst;
                end else begin
                  byteIdx  <= byteIdx + ByteW'(1);
                  bitIdx   <= 3'd7;
                  neoDataQ <= maskQ;
                  for (int unsigned c = 0; c < CHANNELS; c++)
                    dataQ[c] <= pixelMem[MemAw'(c * BYTES_PER_CHANNEL + 32'(byteIdx) + 1)];
                end
              end else begin
                bitIdx   <= bitIdx - 3'd1;
                neoDataQ <= maskQ;
              end
            end else begin
              slot <= slot + 3'd1;
              // Next slot stays high while below 5 ticks for a '1', below 2 for a '0'.
              for (int unsigned c = 0; c < CHANNELS; c++)
                neoDataQ[c] <= maskQ[c] & (dataQ[c][bitIdx] ? (slot < 3'd4) : (slot < 3'd1));
            end
          end
        end
        StRst: begin
          neoDataQ <= '0;
          if (tick) begin
            if (rstCnt == RstW'(RESET_DELAY - 1)) begin
              done   <= 1'b1;
              stateQ <= cont ? StLoad : StIdle;
            end else begin
              rstCnt <= rstCnt + RstW'(1);
            end
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign apbPrData  = prData;
  assign apbPready  = 1'b1;
  assign apbPslverr = pslverr;
  assign neoData    = neoDataQ;
  assign neoState   = stateQ;

endmodule

// File: tb/tb_anton_neopixel_apb_multi.sv
// Bench for anton_neopixel_apb_multi: APB register table, frame waveforms from a tick-level
// model of the WS2812 encoding, and hand-built sequences for continuous mode, sync and reset.
module tb_anton_neopixel_apb_multi;

  localparam int CH = 2;
  localparam int BPC = 2;
  localparam int CD = 2;
  localparam int RD = 4;
  localparam int SendCyc = 64 * BPC * CD;
  localparam int RstCyc = RD * CD;
  localparam int FrameCyc = 1 + SendCyc + RstCyc;

  logic          apbPclk, apbPresern, syncStart, apbPselx, apbPenable, apbPwrite;
  logic [19:0]   apbPaddr;
  logic [7:0]    apbPwData, apbPrData;
  logic          apbPready, apbPslverr;
  logic [CH-1:0] neoData;
  logic [1:0]    neoState;

  int total = 0;
  int bad = 0;

  logic [7:0] mdlBuf [CH][BPC];
  logic [7:0] mdlCtrl;
  logic [1:0] mdlMask;

  typedef struct {
    logic        wr;
    logic [17:0] w;
    logic [7:0]  wd;
    logic [7:0]  expRd;
    logic        expErr;
  } apbVecT;

  apbVecT vecs[18];

  anton_neopixel_apb_multi #(
    .CHANNELS(CH), .BYTES_PER_CHANNEL(BPC), .CLK_DIV(CD), .RESET_DELAY(RD)
  ) dut (
    .apbPclk(apbPclk), .apbPresern(apbPresern), .syncStart(syncStart),
    .apbPselx(apbPselx), .apbPenable(apbPenable), .apbPwrite(apbPwrite),
    .apbPaddr(apbPaddr), .apbPwData(apbPwData), .apbPrData(apbPrData),
    .apbPready(apbPready), .apbPslverr(apbPslverr), .neoData(neoData), .neoState(neoState)
  );

  initial begin
    apbPclk = 1'b0;
    forever #5 apbPclk = ~apbPclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Buffer word index: W[17]=1, byte in W[0] (BPC=2), channel in W[1] (CH=2).
  function automatic logic [17:0] bufW(input int c, input int b);
    return 18'h20000 + 18'(c * 2 + b);
  endfunction

  // Expected line levels k cycles into SEND: 64 ticks per byte, 8 per bit, MSB first.
  function automatic logic [CH-1:0] expWave(input int k, input logic [CH-1:0] mask);
    logic [CH-1:0] res;
    logic [7:0] v;
    int t, byteI, bitPos, slotI;
    t = k / CD;
    byteI = t / 64;
    bitPos = 7 - ((t / 8) % 8);
    slotI = t % 8;
    for (int c = 0; c < CH; c++) begin
      v = mdlBuf[c][byteI];
      res[c] = mask[c] && (slotI < (v[bitPos] ? 5 : 2));
    end
    return res;
  endfunction

  // Called one step after an edge; one access takes two edges, write commits on the second.
  task automatic apbXfer(input logic wr, input logic [17:0] w, input logic [7:0] wd,
                         output logic [7:0] rd, output logic err);
    apbPselx = 1'b1;
    apbPenable = 1'b0;
    apbPwrite = wr;
    apbPaddr = {w, 2'($urandom_range(3))};
    apbPwData = wd;
    @(posedge apbPclk); #1;
    apbPenable = 1'b1;
    rd = apbPrData;
    err = apbPslverr;
    @(posedge apbPclk); #1;
    apbPselx = 1'b0;
    apbPenable = 1'b0;
    apbPwrite = 1'b0;
  endtask

  task automatic apbWr(input string name, input logic [17:0] w, input logic [7:0] wd);
    logic [7:0] d;
    logic e;
    apbXfer(1'b1, w, wd, d, e);
    check({name, " wr err"}, 32'(e), 0);
  endtask

  task automatic apbRd(input string name, input logic [17:0] w, input logic [7:0] expD,
                       input logic expE);
    logic [7:0] d;
    logic e;
    apbXfer(1'b0, w, 8'h00, d, e);
    check({name, " rd data"}, 32'(d), 32'(expD));
    check({name, " rd err"}, 32'(e), 32'(expE));
  endtask

  // Entered in the LOAD cycle; leaves one step after the edge that ends RST.
  task automatic runFrame(input string name, input logic [CH-1:0] mask, input logic [1:0] nextSt);
    int waveBad = 0;
    int stBad = 0;
    check({name, " load"}, 32'(neoState), 1);
    for (int k = 0; k < SendCyc; k++) begin
      @(posedge apbPclk); #1;
      if (neoData !== expWave(k, mask)) waveBad++;
      if (neoState !== 2'd2) stBad++;
    end
    for (int k = 0; k < RstCyc; k++) begin
      @(posedge apbPclk); #1;
      if (neoData !== '0) waveBad++;
      if (neoState !== 2'd3) stBad++;
    end
    @(posedge apbPclk); #1;
    check({name, " wave"}, 32'(waveBad), 0);
    check({name, " states"}, 32'(stBad), 0);
    check({name, " next"}, 32'(neoState), 32'(nextSt));
  endtask

  task automatic idleFor(input string name, input int n);
    int stBad = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge apbPclk); #1;
      if (neoState !== 2'd0 || neoData !== '0) stBad++;
    end
    check({name, " idle"}, 32'(stBad), 0);
  endtask

  task automatic loadBuf();
    for (int c = 0; c < CH; c++)
      for (int b = 0; b < BPC; b++) apbWr("buf", bufW(c, b), mdlBuf[c][b]);
  endtask

  initial begin
    logic [7:0] d;
    logic e;
    logic [17:0] w;
    int kind;

    apbPresern = 1'b0;
    syncStart = 1'b0;
    apbPselx = 1'b0;
    apbPenable = 1'b0;
    apbPwrite = 1'b0;
    apbPaddr = '0;
    apbPwData = '0;
    #3;
    check("reset neoData", 32'(neoData), 0);
    check("reset neoState", 32'(neoState), 0);
    check("reset prdata", 32'(apbPrData), 0);
    check("reset pslverr", 32'(apbPslverr), 0);
    check("pready", 32'(apbPready), 1);
    #19 apbPresern = 1'b1;
    @(posedge apbPclk); #1;

    // Register map and error decode.
    vecs[0]  = '{1'b0, 18'h00000, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 18'h00001, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 18'h00002, 8'h00, 8'h03, 1'b0};
    vecs[3]  = '{1'b1, 18'h20001, 8'h11, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 18'h20005, 8'hEE, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 18'h20001, 8'h00, 8'h11, 1'b0};
    vecs[6]  = '{1'b0, 18'h00003, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 18'h00003, 8'h55, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 18'h20005, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 18'h00002, 8'hFF, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 18'h00002, 8'h00, 8'h03, 1'b0};
    vecs[11] = '{1'b1, 18'h20002, 8'h5A, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 18'h20002, 8'h00, 8'h5A, 1'b0};
    vecs[13] = '{1'b0, 18'h0FFFF, 8'h00, 8'h00, 1'b1};
    vecs[14] = '{1'b1, 18'h00000, 8'h05, 8'h00, 1'b0};
    vecs[15] = '{1'b0, 18'h00000, 8'h00, 8'h05, 1'b0};
    vecs[16] = '{1'b1, 18'h00000, 8'h00, 8'h00, 1'b0};
    vecs[17] = '{1'b0, 18'h00001, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 18; i++) begin
      apbXfer(vecs[i].wr, vecs[i].w, vecs[i].wd, d, e);
      check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].expErr));
      if (!vecs[i].wr) check($sformatf("vec%0d data", i), 32'(d), 32'(vecs[i].expRd));
    end
    idleFor("after table", 3);

    // Known frame.
    mdlBuf[0][0] = 8'hA5; mdlBuf[0][1] = 8'h00;
    mdlBuf[1][0] = 8'hFF; mdlBuf[1][1] = 8'h81;
    loadBuf();
    apbWr("t1 start", 18'h0, 8'h02);
    runFrame("t1", 2'b11, 2'd0);
    apbRd("t1 status", 18'h1, 8'h08, 1'b0);

    // DONE clear, then a clear landing on the RST-exit edge loses to the set.
    apbWr("t6 clr", 18'h1, 8'h08);
    apbRd("t6 cleared", 18'h1, 8'h00, 1'b0);
    apbWr("t6 start", 18'h0, 8'h02);
    repeat (FrameCyc - 2) @(posedge apbPclk);
    #1;
    check("t6 in rst", 32'(neoState), 3);
    apbWr("t6 clr exit", 18'h1, 8'h08);
    apbRd("t6 set wins", 18'h1, 8'h08, 1'b0);
    apbWr("t6 clr2", 18'h1, 8'h08);

    // Random register traffic and decode against the model.
    mdlCtrl = 8'h00;
    mdlMask = 2'b11;
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(5));
      case (kind)
        0: begin
          d = 8'($urandom) & 8'hFD;
          apbWr("rnd ctrl", 18'h0, d);
          mdlCtrl = d & 8'h05;
        end
        1: begin
          d = 8'($urandom);
          apbWr("rnd mask", 18'h2, d);
          mdlMask = d[1:0];
        end
        2: begin
          w = 18'($urandom_range(2));
          apbRd("rnd reg", w, (w == 0) ? mdlCtrl : (w == 1) ? 8'h00 : {6'b0, mdlMask}, 1'b0);
        end
        3: begin
          w = 18'($urandom_range(1));
          apbRd("rnd buf", bufW(int'(w), i % 2), mdlBuf[int'(w)][i % 2], 1'b0);
        end
        4: apbRd("rnd badbuf", 18'h20000 | 18'($urandom_range(32767, 1) << 2) | 18'($urandom_range(3)),
                 8'h00, 1'b1);
        default: apbRd("rnd badreg", 18'($urandom_range(16'hFFFF, 3)), 8'h00, 1'b1);
      endcase
    end
    apbWr("restore ctrl", 18'h0, 8'h00);
    apbWr("restore mask", 18'h2, 8'h03);
    idleFor("after rnd", 2);

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < CH; c++)
        for (int b = 0; b < BPC; b++) mdlBuf[c][b] = 8'($urandom);
      mdlMask = 2'($urandom_range(3));
      loadBuf();
      apbWr("rf mask", 18'h2, {6'b0, mdlMask});
      apbWr("rf start", 18'h0, 8'h02);
      runFrame($sformatf("rf%0d", f), mdlMask, 2'd0);
      apbRd("rf done", 18'h1, 8'h08, 1'b0);
      apbWr("rf clr", 18'h1, 8'h08);
    end
    apbWr("mask3", 18'h2, 8'h03);

    // START while busy is dropped.
    apbWr("t3 start", 18'h0, 8'h02);
    fork
      runFrame("t3 busy", 2'b11, 2'd0);
      begin
        logic [7:0] d2;
        logic e2;
        repeat (50) @(posedge apbPclk);
        #1;
        apbXfer(1'b1, 18'h0, 8'h02, d2, e2);
      end
    join
    idleFor("t3 no queue", 4);

    // Continuous mode, CONT cleared during frame 2.
    apbWr("t3 cont", 18'h0, 8'h03);
    fork
      begin
        runFrame("t3 f1", 2'b11, 2'd1);
        runFrame("t3 f2", 2'b11, 2'd0);
      end
      begin
        logic [7:0] d2;
        logic e2;
        repeat (FrameCyc + 40) @(posedge apbPclk);
        #1;
        apbXfer(1'b1, 18'h0, 8'h00, d2, e2);
      end
    join
    idleFor("t3 two frames", 20);

    // External sync start with channel 0 masked; mask change mid-frame waits.
    apbWr("t4 syncen", 18'h0, 8'h04);
    apbWr("t4 mask", 18'h2, 8'h02);
    syncStart = 1'b1;
    @(posedge apbPclk); #1;
    syncStart = 1'b0;
    fork
      runFrame("t4 sync", 2'b10, 2'd0);
      begin
        logic [7:0] d2;
        logic e2;
        repeat (30) @(posedge apbPclk);
        #1;
        apbXfer(1'b1, 18'h2, 8'h03, d2, e2);
      end
    join
    // START and syncStart rising on the same edge give one frame.
    fork
      apbWr("t4 both", 18'h0, 8'h06);
      begin
        @(posedge apbPclk);
        #2 syncStart = 1'b1;
      end
    join
    syncStart = 1'b0;
    runFrame("t4 single", 2'b11, 2'd0);
    idleFor("t4 one start", 3);
    apbWr("t4 syncoff", 18'h0, 8'h00);
    syncStart = 1'b1;
    @(posedge apbPclk); #1;
    syncStart = 1'b0;
    idleFor("t4 ignored", 6);

    // Reset mid-SEND at bit 3 of byte 1 (first slot, line high).
    for (int c = 0; c < CH; c++)
      for (int b = 0; b < BPC; b++) mdlBuf[c][b] = 8'($urandom);
    loadBuf();
    apbWr("t5 start", 18'h0, 8'h02);
    repeat (1 + 96 * CD) @(posedge apbPclk);
    #1;
    check("t5 high before", 32'(neoData), 32'(2'b11));
    #2 apbPresern = 1'b0;
    #1;
    check("t5 neoData", 32'(neoData), 0);
    check("t5 neoState", 32'(neoState), 0);
    @(negedge apbPclk);
    apbPresern = 1'b1;
    @(posedge apbPclk); #1;
    apbRd("t5 ctrl", 18'h0, 8'h00, 1'b0);
    apbRd("t5 status", 18'h1, 8'h00, 1'b0);
    apbRd("t5 mask", 18'h2, 8'h03, 1'b0);
    apbWr("t5 restart", 18'h0, 8'h02);
    runFrame("t5 frame", 2'b11, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
